// File: rtl/tpu_pkg.sv
// Shared TPU definitions: sequencer state encoding, run-length helpers
// and the TPU opcode values that the decode stage also uses.
package tpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tpu_seq_state_t;

   // Default array size used by the decode side.
   localparam int TPU_DIM = 4;

   // A DIM x DIM systolic array needs 3*DIM-2 steps to drain a full product.
   function automatic int tpu_matmul_cycles(input int dim);
      return 3 * dim - 2;
   endfunction

   // Counter width able to hold 0 .. n-1 (never narrower than one bit).
   function automatic int tpu_cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int MATMUL_CYCLES = tpu_matmul_cycles(TPU_DIM);

   // TPU opcodes, shared with decode.
   localparam logic [6:0] OP_LAM    = 7'h50;
   localparam logic [6:0] OP_LBM    = 7'h51;
   localparam logic [6:0] OP_LACC   = 7'h52;
   localparam logic [6:0] OP_MATMUL = 7'h53;
   localparam logic [6:0] OP_RACC   = 7'h54;

endpackage

// File: rtl/tpu_row_tracker.sv
// Tracks which rows of the A and B operand buffers hold valid data.
// A row bit is set when that row is written and all bits are cleared
// when a matmul consumes the operands.
module tpu_row_tracker
   import tpu_pkg::*;
#(
   parameter int DIM = 4,
   localparam int RW = $clog2(DIM)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          set_a,
   input  logic          set_b,
   input  logic          consume,
   input  logic [RW-1:0] row,
   output logic [DIM-1:0] a_mask,
   output logic [DIM-1:0] b_mask,
   output logic          a_full,
   output logic          b_full
);

   logic [DIM-1:0] a_mask_reg, a_mask_next;
   logic [DIM-1:0] b_mask_reg, b_mask_next;

   // Per-row next value: consume wins over a same-cycle write.
   for (genvar gi = 0; gi < DIM; gi++) begin : g_row
      assign a_mask_next[gi] = consume ? 1'b0 :
                               (set_a && (row == RW'(gi))) ? 1'b1 : a_mask_reg[gi];
      assign b_mask_next[gi] = consume ? 1'b0 :
                               (set_b && (row == RW'(gi))) ? 1'b1 : b_mask_reg[gi];
   end

   // Mask registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_mask_reg <= '0;
         b_mask_reg <= '0;
      end else begin
         a_mask_reg <= a_mask_next;
         b_mask_reg <= b_mask_next;
      end
   end

   assign a_mask = a_mask_reg;
   assign b_mask = b_mask_reg;
   assign a_full = &a_mask_reg;
   assign b_full = &b_mask_reg;

endmodule

// File: rtl/tpu_sequencer.sv
// Sequencer between decode and the systolic-array TPU: issues registered
// row writes / accumulator reads, runs matmuls for a fixed number of
// cycles and stalls decode while the array is busy.
module tpu_sequencer
   import tpu_pkg::*;
#(
   parameter int DIM = 4,
   parameter int DATA_W = 32,
   localparam int RUN_CYCLES = tpu_matmul_cycles(DIM),
   localparam int RW = $clog2(DIM),
   localparam int CYC_W = tpu_cnt_width(RUN_CYCLES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tpu_start_i,
   input  logic              tpu_write_enable_A_i,
   input  logic              tpu_write_enable_B_i,
   input  logic              tpu_write_enable_C_i,
   input  logic              racc_i,
   input  logic [RW-1:0]     row_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              tpu_wr_a_o,
   output logic              tpu_wr_b_o,
   output logic              tpu_wr_c_o,
   output logic [RW-1:0]     tpu_row_o,
   output logic [DATA_W-1:0] tpu_data_o,
   output logic              tpu_run_o,
   output logic [CYC_W-1:0]  tpu_cycle_o,
   output logic              racc_valid_o,
   output logic              stall_o,
   output logic              done_o,
   output logic              illegal_o
);

   tpu_seq_state_t state_reg, state_next;
   logic [CYC_W-1:0]  cycle_reg;
   logic              wr_a_reg, wr_b_reg, wr_c_reg, racc_reg, illegal_reg;
   logic [RW-1:0]     row_reg;
   logic [DATA_W-1:0] data_reg;

   logic [4:0] cmd_vec;
   logic       any_cmd, multi_cmd, accept, legal, operands_ready, mm_go, last_cycle;
   logic [DIM-1:0] a_mask, b_mask;
   logic       a_full, b_full;

   assign cmd_vec   = {tpu_start_i, tpu_write_enable_A_i, tpu_write_enable_B_i,
                       tpu_write_enable_C_i, racc_i};
   assign any_cmd   = |cmd_vec;
   assign multi_cmd = (cmd_vec & (cmd_vec - 5'd1)) != 5'd0;
   // Commands are only taken in IDLE; stall is never raised there.
   assign accept    = (state_reg == IDLE) && any_cmd;
   assign legal     = accept && !multi_cmd;
   assign operands_ready = a_full && b_full;
   assign mm_go     = legal && tpu_start_i && operands_ready;
   assign last_cycle = (cycle_reg == CYC_W'(RUN_CYCLES - 1));

   tpu_row_tracker #(.DIM(DIM)) u_tracker (
      .clk     (clk),
      .rst_n   (rst_n),
      .set_a   (legal && tpu_write_enable_A_i),
      .set_b   (legal && tpu_write_enable_B_i),
      .consume (mm_go),
      .row     (row_i),
      .a_mask  (a_mask),
      .b_mask  (b_mask),
      .a_full  (a_full),
      .b_full  (b_full)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (mm_go) state_next = RUN;
         RUN:     if (last_cycle) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      tpu_run_o = 1'b0;
      done_o    = 1'b0;
      stall_o   = 1'b0;
      if (state_reg == RUN)  tpu_run_o = 1'b1;
      if (state_reg == DONE) done_o    = 1'b1;
      if (state_reg != IDLE) stall_o   = any_cmd;
   end

   // Run counter: counts only while staying in RUN, zero everywhere else.
   always_ff @(posedge clk) begin
      if (!rst_n)
         cycle_reg <= '0;
      else if ((state_reg == RUN) && (state_next == RUN))
         cycle_reg <= cycle_reg + CYC_W'(1);
      else
         cycle_reg <= '0;
   end

   // Registered issue path: strobes, row/data and the illegal pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_a_reg    <= 1'b0;
         wr_b_reg    <= 1'b0;
         wr_c_reg    <= 1'b0;
         racc_reg    <= 1'b0;
         illegal_reg <= 1'b0;
         row_reg     <= '0;
         data_reg    <= '0;
      end else begin
         wr_a_reg    <= legal && tpu_write_enable_A_i;
         wr_b_reg    <= legal && tpu_write_enable_B_i;
         wr_c_reg    <= legal && tpu_write_enable_C_i;
         racc_reg    <= legal && racc_i;
         illegal_reg <= accept && (multi_cmd || (tpu_start_i && !operands_ready));
         if (legal && !tpu_start_i)
            row_reg <= row_i;
         if (legal && (tpu_write_enable_A_i || tpu_write_enable_B_i || tpu_write_enable_C_i))
            data_reg <= data_i;
      end
   end

   assign tpu_wr_a_o   = wr_a_reg;
   assign tpu_wr_b_o   = wr_b_reg;
   assign tpu_wr_c_o   = wr_c_reg;
   assign racc_valid_o = racc_reg;
   assign illegal_o    = illegal_reg;
   assign tpu_row_o    = row_reg;
   assign tpu_data_o   = data_reg;
   assign tpu_cycle_o  = cycle_reg;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer (DIM=4, 10-cycle matmul runs).
module tb_tpu_sequencer;

   logic        clk;
   logic        rst_n;
   logic        tpu_start_i, tpu_write_enable_A_i, tpu_write_enable_B_i;
   logic        tpu_write_enable_C_i, racc_i;
   logic [1:0]  row_i;
   logic [31:0] data_i;
   logic        tpu_wr_a_o, tpu_wr_b_o, tpu_wr_c_o;
   logic [1:0]  tpu_row_o;
   logic [31:0] tpu_data_o;
   logic        tpu_run_o;
   logic [3:0]  tpu_cycle_o;
   logic        racc_valid_o, stall_o, done_o, illegal_o;

   int checks = 0;
   int errors = 0;

   tpu_sequencer #(.DIM(4), .DATA_W(32)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .tpu_start_i          (tpu_start_i),
      .tpu_write_enable_A_i (tpu_write_enable_A_i),
      .tpu_write_enable_B_i (tpu_write_enable_B_i),
      .tpu_write_enable_C_i (tpu_write_enable_C_i),
      .racc_i               (racc_i),
      .row_i                (row_i),
      .data_i               (data_i),
      .tpu_wr_a_o           (tpu_wr_a_o),
      .tpu_wr_b_o           (tpu_wr_b_o),
      .tpu_wr_c_o           (tpu_wr_c_o),
      .tpu_row_o            (tpu_row_o),
      .tpu_data_o           (tpu_data_o),
      .tpu_run_o            (tpu_run_o),
      .tpu_cycle_o          (tpu_cycle_o),
      .racc_valid_o         (racc_valid_o),
      .stall_o              (stall_o),
      .done_o               (done_o),
      .illegal_o            (illegal_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One command vector: inputs {start,A,B,C,racc}, row, data and the
   // expected strobes {wr_a,wr_b,wr_c,racc_valid}, illegal and run one cycle later.
   typedef struct {
      string       name;
      logic [4:0]  cmd;
      logic [1:0]  row;
      logic [31:0] data;
      logic [3:0]  e_strb;
      logic        e_ill;
      logic        e_run;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input string n, input logic [4:0] c, input logic [1:0] r,
                               input logic [31:0] d, input logic [3:0] s,
                               input logic il, input logic rn);
      vec_t v;
      v.name = n; v.cmd = c; v.row = r; v.data = d;
      v.e_strb = s; v.e_ill = il; v.e_run = rn;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [4:0] c, input logic [1:0] r, input logic [31:0] d);
      {tpu_start_i, tpu_write_enable_A_i, tpu_write_enable_B_i,
       tpu_write_enable_C_i, racc_i} = c;
      row_i  = r;
      data_i = d;
   endtask

   // Called at a negedge: drive, wait one cycle, compare registered outputs.
   task automatic apply_vec(input vec_t v);
      drive(v.cmd, v.row, v.data);
      @(negedge clk);
      chk({v.name, ".strobes"}, {28'd0, tpu_wr_a_o, tpu_wr_b_o, tpu_wr_c_o, racc_valid_o},
          {28'd0, v.e_strb});
      chk({v.name, ".illegal"}, {31'd0, illegal_o}, {31'd0, v.e_ill});
      chk({v.name, ".run"}, {31'd0, tpu_run_o}, {31'd0, v.e_run});
      if (v.e_strb != 4'b0000) chk({v.name, ".row"}, {30'd0, tpu_row_o}, {30'd0, v.row});
      if (v.e_strb[3:1] != 3'b000) chk({v.name, ".data"}, tpu_data_o, v.data);
      $display("vec %-12s cmd=%b row=%0d data=0x%0h -> strb=%b ill=%b run=%b",
               v.name, v.cmd, v.row, v.data,
               {tpu_wr_a_o, tpu_wr_b_o, tpu_wr_c_o, racc_valid_o}, illegal_o, tpu_run_o);
   endtask

   task automatic run_table();
      foreach (tbl[i]) apply_vec(tbl[i]);
      drive(5'b00000, 2'd0, 32'd0);
      tbl.delete();
   endtask

   // Follows a run whose cycle 0 was just checked. Optionally raises lacc
   // row 2 at cycle lacc_at, or pulls reset at cycle rst_at.
   task automatic run_seq(input int lacc_at, input int rst_at);
      for (int k = 1; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("run.c%0d.run", k), {31'd0, tpu_run_o}, 32'd1);
         chk($sformatf("run.c%0d.cycle", k), {28'd0, tpu_cycle_o}, k);
         chk($sformatf("run.c%0d.idle_out", k),
             {27'd0, done_o, tpu_wr_a_o, tpu_wr_b_o, tpu_wr_c_o, racc_valid_o}, 32'd0);
         if (lacc_at > 0 && k > lacc_at)
            chk($sformatf("run.c%0d.stall", k), {31'd0, stall_o}, 32'd1);
         if (k == lacc_at) begin
            chk("run.pre_stall", {31'd0, stall_o}, 32'd0);
            drive(5'b00010, 2'd2, 32'h0000_ABCD);
            #1;
            chk("run.stall_rise", {31'd0, stall_o}, 32'd1);
         end
         if (k == rst_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            chk("rst.run", {31'd0, tpu_run_o}, 32'd0);
            chk("rst.cycle", {28'd0, tpu_cycle_o}, 32'd0);
            chk("rst.done", {31'd0, done_o}, 32'd0);
            rst_n = 1'b1;
            for (int j = 0; j < 12; j++) begin
               @(negedge clk);
               chk("rst.no_done", {30'd0, done_o, tpu_run_o}, 32'd0);
            end
            $display("run aborted by reset at cycle %0d", k);
            return;
         end
      end
      @(negedge clk);
      chk("done.pulse", {31'd0, done_o}, 32'd1);
      chk("done.run", {31'd0, tpu_run_o}, 32'd0);
      chk("done.cycle", {28'd0, tpu_cycle_o}, 32'd0);
      if (lacc_at > 0) chk("done.stall", {31'd0, stall_o}, 32'd1);
      @(negedge clk);
      chk("idle.done", {31'd0, done_o}, 32'd0);
      chk("idle.stall", {31'd0, stall_o}, 32'd0);
      chk("idle.wr_c", {31'd0, tpu_wr_c_o}, 32'd0);
      if (lacc_at > 0) begin
         @(posedge clk);
         #1 drive(5'b00000, 2'd0, 32'd0);
         @(negedge clk);
         chk("held.wr_c", {31'd0, tpu_wr_c_o}, 32'd1);
         chk("held.row", {30'd0, tpu_row_o}, 32'd2);
         chk("held.data", tpu_data_o, 32'h0000_ABCD);
         @(negedge clk);
         chk("held.once", {31'd0, tpu_wr_c_o}, 32'd0);
      end
      $display("run complete lacc_at=%0d", lacc_at);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(5'b00000, 2'd0, 32'd0);
      repeat (2) @(negedge clk);
      chk("reset.outs", {tpu_wr_a_o, tpu_wr_b_o, tpu_wr_c_o, racc_valid_o, tpu_run_o,
                          stall_o, done_o, illegal_o, tpu_row_o, tpu_cycle_o}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle.outs", {tpu_wr_a_o, tpu_wr_b_o, tpu_wr_c_o, racc_valid_o, tpu_run_o,
                            stall_o, done_o, illegal_o, tpu_row_o, tpu_cycle_o}, 32'd0);
         chk("idle.data", tpu_data_o, 32'd0);
         $display("idle cycle %0d outputs quiet", i);
      end

      // Partial A load, matmul rejected, complete load, corner commands, run.
      tbl.push_back(mk("lam0",    5'b01000, 2'd0, 32'h11, 4'b1000, 0, 0));
      tbl.push_back(mk("lam1",    5'b01000, 2'd1, 32'h22, 4'b1000, 0, 0));
      tbl.push_back(mk("lam2",    5'b01000, 2'd2, 32'h33, 4'b1000, 0, 0));
      tbl.push_back(mk("lbm0",    5'b00100, 2'd0, 32'h55, 4'b0100, 0, 0));
      tbl.push_back(mk("lbm1",    5'b00100, 2'd1, 32'h66, 4'b0100, 0, 0));
      tbl.push_back(mk("lbm2",    5'b00100, 2'd2, 32'h77, 4'b0100, 0, 0));
      tbl.push_back(mk("lbm3",    5'b00100, 2'd3, 32'h88, 4'b0100, 0, 0));
      tbl.push_back(mk("mm_part", 5'b10000, 2'd0, 32'h0,  4'b0000, 1, 0));
      tbl.push_back(mk("idle",    5'b00000, 2'd0, 32'h0,  4'b0000, 0, 0));
      tbl.push_back(mk("lam3",    5'b01000, 2'd3, 32'h44, 4'b1000, 0, 0));
      tbl.push_back(mk("lam3_rw", 5'b01000, 2'd3, 32'h45, 4'b1000, 0, 0));
      tbl.push_back(mk("multi",   5'b11000, 2'd1, 32'h99, 4'b0000, 1, 0));
      tbl.push_back(mk("racc1",   5'b00001, 2'd1, 32'h0,  4'b0001, 0, 0));
      tbl.push_back(mk("lacc2",   5'b00010, 2'd2, 32'h1234, 4'b0010, 0, 0));
      tbl.push_back(mk("mm_ok",   5'b10000, 2'd0, 32'h0,  4'b0000, 0, 1));
      run_table();
      chk("mm_ok.cycle0", {28'd0, tpu_cycle_o}, 32'd0);
      run_seq(3, 0);

      // Operands consumed: matmul now illegal; full reload runs normally.
      tbl.push_back(mk("mm_empty", 5'b10000, 2'd0, 32'h0, 4'b0000, 1, 0));
      for (int r = 0; r < 4; r++)
         tbl.push_back(mk($sformatf("lam%0d", r), 5'b01000, 2'(r), 32'h11 * (r + 1), 4'b1000, 0, 0));
      for (int r = 0; r < 4; r++)
         tbl.push_back(mk($sformatf("lbm%0d", r), 5'b00100, 2'(r), 32'hA0 + r, 4'b0100, 0, 0));
      tbl.push_back(mk("mm_full",  5'b10000, 2'd0, 32'h0, 4'b0000, 0, 1));
      run_table();
      run_seq(0, 0);

      // Reload, then reset during the run; masks must be cleared afterwards.
      for (int r = 0; r < 4; r++) begin
         tbl.push_back(mk("lam", 5'b01000, 2'(r), 32'h100 + r, 4'b1000, 0, 0));
         tbl.push_back(mk("lbm", 5'b00100, 2'(r), 32'h200 + r, 4'b0100, 0, 0));
      end
      tbl.push_back(mk("mm_rst", 5'b10000, 2'd0, 32'h0, 4'b0000, 0, 1));
      run_table();
      run_seq(0, 5);
      tbl.push_back(mk("mm_after_rst", 5'b10000, 2'd0, 32'h0, 4'b0000, 1, 0));
      run_table();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tpu_sequencer.md
Name: tpu_sequencer

Overview:
- Sits between the decode stage and the systolic-array TPU.
- Accepts one decoded TPU command per cycle: lam, lbm, lacc, matmul or racc.
- Drives registered row writes into the A, B and C buffers, and runs a matmul for a fixed cycle count.
- Tracks which A/B rows are loaded, and stalls the pipeline while the array is busy.

Parameters:
- DIM, 4, systolic array dimension (rows per matrix); power of two, at least 2.
- DATA_W, 32, width of one row word on the write path.
- MATMUL_CYCLES, 3*DIM-2, array run length in cycles; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- tpu_start_i  input  1  matmul decoded.
- tpu_write_enable_A_i  input  1  lam decoded.
- tpu_write_enable_B_i  input  1  lbm decoded.
- tpu_write_enable_C_i  input  1  lacc decoded.
- racc_i  input  1  racc decoded.
- row_i  input  $clog2(DIM)  target row for lam/lbm/lacc/racc.
- data_i  input  DATA_W  row data for lam/lbm/lacc.
- tpu_wr_a_o  output  1  A-buffer row write strobe.
- tpu_wr_b_o  output  1  B-buffer row write strobe.
- tpu_wr_c_o  output  1  accumulator row write strobe.
- tpu_row_o  output  $clog2(DIM)  row address to TPU.
- tpu_data_o  output  DATA_W  row write data to TPU.
- tpu_run_o  output  1  array step enable.
- tpu_cycle_o  output  $clog2(MATMUL_CYCLES)  current run cycle index.
- racc_valid_o  output  1  accumulator read on tpu_row_o; writeback captures TPU data.
- stall_o  output  1  hold decode/issue; combinational.
- done_o  output  1  one-cycle pulse when a matmul completes.
- illegal_o  output  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs except stall_o are 0; state=IDLE; counter=0; a_mask=b_mask=0.
  - stall_o is 0 while in IDLE.
  - Reset mid-RUN aborts the run immediately; no done_o is produced.
- States:
  - IDLE: ready to accept commands.
  - RUN: tpu_run_o=1 and counter increments each cycle.
  - DONE: one cycle; done_o=1, then back to IDLE.
- Accept rule: a command is accepted only in IDLE with stall_o=0.
- stall_o = (state!=IDLE) & (any command input high).
  - The pipeline holds the command inputs stable while stalled.
  - The command is accepted on the IDLE cycle after DONE.
- Multiple command inputs high in one cycle: illegal.
  - illegal_o pulses next cycle; nothing is issued; masks are unchanged.
- lam accepted: next cycle tpu_wr_a_o=1, tpu_row_o=row_i and tpu_data_o=data_i (registered, 1-cycle latency); a_mask[row_i] set.
- lbm accepted: same as lam with tpu_wr_b_o; sets b_mask[row_i].
- lacc accepted: same pattern with tpu_wr_c_o; masks are unaffected.
- Rewriting an already-loaded row is legal; the mask bit stays set.
- racc accepted: next cycle racc_valid_o=1 and tpu_row_o=row_i for one cycle.
- matmul accepted:
  - Requires a_mask and b_mask all ones. Otherwise illegal_o pulses next cycle, state stays IDLE, and the masks are kept.
  - If legal: next cycle state=RUN, tpu_run_o=1, tpu_cycle_o=0, and a_mask/b_mask are cleared (operands consumed).
- RUN:
  - tpu_cycle_o increments each cycle.
  - On the cycle where tpu_cycle_o = MATMUL_CYCLES-1, the next state is DONE.
  - tpu_run_o is high for exactly MATMUL_CYCLES cycles.
- DONE: done_o=1 and tpu_run_o=0; counter resets to 0.
- Back-to-back legal commands in IDLE: accepted every cycle, giving a 1-cycle-latency write stream with no bubbles.
- Write strobes and racc_valid_o are never asserted while tpu_run_o=1.
- Counter never wraps; it is width-checked so that MATMUL_CYCLES-1 fits.

Decomposition:
- Shared package tpu_pkg holds:
  - the enum tpu_seq_state_t {IDLE, RUN, DONE};
  - localparam MATMUL_CYCLES and the counter-width function;
  - TPU opcode constants 7'h50–7'h54, shared with decode.
- One sub-module, tpu_row_tracker:
  - holds the DIM-bit a_mask and b_mask;
  - set on write, clear on consume;
  - provides the all-ones flags.
- The FSM, counter and output registers stay in tpu_sequencer.

Test Plan (DIM=4, MATMUL_CYCLES=10):
- Reset then idle -> all outputs 0 for 5 cycles.
- lam rows 0–3 with data 0x11..0x44, then lbm rows 0–3, then matmul -> wr_a/wr_b strobe 1 cycle after each command with the matching row/data; tpu_run_o high for exactly 10 cycles with tpu_cycle_o 0..9; done_o pulses on cycle 11 after accept.
- lam rows 0–2 only, lbm rows 0–3, matmul -> illegal_o pulse, tpu_run_o stays 0; then lam row 3 plus matmul runs normally.
- During RUN cycle 3, assert lacc row 2 data 0xABCD -> stall_o=1 through DONE; wr_c_o, row 2 and 0xABCD appear 1 cycle after the returned-IDLE accept.
- tpu_start_i and tpu_write_enable_A_i high together in IDLE -> illegal_o pulse, no strobes, masks unchanged.
- rst_n low at RUN cycle 5 -> next cycle state IDLE, tpu_run_o=0, no done_o, masks 0; then a subsequent matmul is illegal.
